mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-access stage of the 5-stage pipeline. It consumes the EX/MEM register outputs, performs word loads and stores over a variable-latency data-memory handshake, and holds the MEM/WB pipeline register for writeback. It stalls the upstream pipeline while an access is outstanding, and it flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles without ack before a bus error is declared; range 1..1023.
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_result_in  in  32  ALU result / effective address from EX/MEM
- rs2_data_in  in  32  store data from EX/MEM
- rd_addr_in  in  5  destination register from EX/MEM
- MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in  in  1 each  control from EX/MEM; MemRead and MemWrite never both 1
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  1 = store, 0 = load (registered)
- dmem_addr  out  32  word address = latched alu_result_in (registered)
- dmem_wdata  out  32  latched rs2_data_in (registered)
- dmem_rdata  in  32  load data; valid in the dmem_ack cycle
- dmem_ack  in  1  access complete; sampled only while dmem_req = 1
- mem_stall  out  1  combinational; 1 = upstream registers must hold
- alu_result_out, mem_data_out  out  32 each  MEM/WB data
- rd_addr_out  out  5  MEM/WB destination register
- RegWrite_out, MemToReg_out  out  1 each  MEM/WB control
- misalign_err, bus_err  out  1 each  single-cycle error pulses (registered)

## Operation
- A memory op is MemRead_in | MemWrite_in. An op is aligned when alu_result_in[1:0] == 0.
- FSM states:
  - IDLE
    - Aligned memory op: latch address, wdata and we, and drive dmem_req=1 from the next cycle. Go to WAIT with the timeout counter cleared.
    - Misaligned memory op: no request. Load a bubble into MEM/WB (RegWrite_out=0). Pulse misalign_err. Stay in IDLE.
    - Non-memory op: load MEM/WB directly: alu_result_out=alu_result_in, rd/RegWrite/MemToReg from inputs, mem_data_out unchanged. Stay in IDLE.
  - WAIT (dmem_req=1)
    - dmem_ack=1: load MEM/WB with inputs plus mem_data_out=dmem_rdata on loads; on stores mem_data_out is unchanged. Drop dmem_req and go to IDLE.
    - No ack, counter == TIMEOUT_CYCLES-1: drop dmem_req, load a bubble, pulse bus_err, go to IDLE. The instruction is discarded.
    - Otherwise: increment the counter and load a bubble.
- mem_stall = (IDLE & aligned memory op) | (WAIT & ~dmem_ack & ~timeout).
- Upstream holds EX/MEM stable while mem_stall = 1. The stage relies on this and does not re-latch inputs in WAIT, except rd/control, which are taken from the inputs at completion.
- dmem_ack seen in IDLE (late or spurious) is ignored.
- Counter width is clog2(TIMEOUT_CYCLES)+1; it never wraps.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE and the counter to 0.
  - All registered outputs go to 0, including dmem_req, RegWrite_out and the error pulses.
  - An outstanding access is abandoned with no error pulse. An ack arriving after reset is ignored.
- Non-memory op and misaligned op: 1-cycle latency, no stall.
- Memory op with ack k cycles after dmem_req rises (k ≥ 0, ack in the same cycle as the first req = 0):
  - Edge 0 enters WAIT; stall is high from the presenting cycle.
  - MEM/WB is valid after edge k+1.
  - mem_stall drops combinationally in the ack cycle, so EX/MEM advances on the same edge that loads MEM/WB.
  - Back-to-back memory ops: dmem_req goes low for exactly one cycle between accesses.
- Timeout: bus_err is high for the one cycle after the edge on which req drops.
- The path dmem_ack → mem_stall is combinational and is a permitted timing arc.

## Test plan
- Reset: hold rst_n=0 mid-WAIT with dmem_req=1 -> all outputs 0 immediately. Release, then pulse dmem_ack -> no MEM/WB update and state stays IDLE.
- ALU pass-through: add, alu_result_in=0x0000_1234, rd=5, RegWrite=1 -> next cycle alu_result_out=0x1234, rd_addr_out=5, RegWrite_out=1, mem_stall never 1.
- Load with 3-cycle ack delay: lw, addr=0x100, rd=7, MemToReg=1; dmem_rdata=0xDEAD_BEEF -> dmem_addr=0x100 and dmem_we=0 while waiting. Bubbles (RegWrite_out=0) during the wait, mem_stall high for 4 cycles, then mem_data_out=0xDEADBEEF, rd_addr_out=7, RegWrite_out=1.
- Store, ack same cycle: sw addr=0x200, rs2=0x55AA_55AA -> dmem_we=1, dmem_wdata=0x55AA55AA, req high 1 cycle, RegWrite_out=0, stall high 1 cycle.
- Misaligned: lw addr=0x102 -> dmem_req stays 0, misalign_err=1 for one cycle, RegWrite_out=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> req drops after 4 WAIT cycles, bus_err pulses once, mem_stall low. A late ack afterwards is ignored.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : Data-memory request/acknowledge bus between the MEM stage and
//               the data memory.
//               master : dmem_req, dmem_we, dmem_addr, dmem_wdata out;
//                        dmem_rdata, dmem_ack in
//               slave  : the mirror image, for the memory side
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-access pipeline stage. Issues word loads/stores over a
//               variable-latency request/ack bus, stalls upstream while an
//               access is outstanding, holds the MEM/WB register, and flags
//               misaligned accesses and bus timeouts.
// Ports       : clk, rst_n            clock, async active-low reset
//               alu_result_in .. MemToReg_in   EX/MEM register contents
//               dmem                 data-memory bus (master side)
//               mem_stall            combinational upstream hold
//               alu_result_out .. MemToReg_out MEM/WB register contents
//               misalign_err, bus_err single-cycle error pulses
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] alu_result_in,
  input  wire logic [31:0] rs2_data_in,
  input  wire logic [4:0]  rd_addr_in,
  input  wire logic        MemRead_in,
  input  wire logic        MemWrite_in,
  input  wire logic        RegWrite_in,
  input  wire logic        MemToReg_in,
  mem_stage_lsu_if.master  dmem,
  output logic             mem_stall,
  output logic [31:0]      alu_result_out,
  output logic [31:0]      mem_data_out,
  output logic [4:0]       rd_addr_out,
  output logic             RegWrite_out,
  output logic             MemToReg_out,
  output logic             misalign_err,
  output logic             bus_err
);

  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;

  logic w_mem_op;
  logic w_aligned;
  logic w_timeout;

  assign w_mem_op  = MemRead_in | MemWrite_in;
  assign w_aligned = (alu_result_in[1:0] == 2'b00);
  // Ack wins over timeout when both land in the same cycle.
  assign w_timeout = (r_state == ST_WAIT) && !dmem.dmem_ack && (r_cnt == c_cnt_last);

  // The ack term makes this a combinational path from the bus; EX/MEM
  // advances on the same edge that captures the load data.
  assign mem_stall = ((r_state == ST_IDLE) && w_mem_op && w_aligned) ||
                     ((r_state == ST_WAIT) && !dmem.dmem_ack && !w_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      alu_result_out  <= '0;
      mem_data_out    <= '0;
      rd_addr_out     <= '0;
      RegWrite_out    <= 1'b0;
      MemToReg_out    <= 1'b0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Any ack arriving here is late or spurious and is ignored.
          if (w_mem_op && w_aligned) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MemWrite_in;
            dmem.dmem_addr  <= alu_result_in;
            dmem.dmem_wdata <= rs2_data_in;
            r_cnt           <= '0;
            RegWrite_out    <= 1'b0;
            MemToReg_out    <= 1'b0;
            r_state         <= ST_WAIT;
          end else if (w_mem_op) begin
            RegWrite_out <= 1'b0;
            MemToReg_out <= 1'b0;
            misalign_err <= 1'b1;
          end else begin
            alu_result_out <= alu_result_in;
            rd_addr_out    <= rd_addr_in;
            RegWrite_out   <= RegWrite_in;
            MemToReg_out   <= MemToReg_in;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_ack) begin
            // Upstream held EX/MEM stable, so the inputs still describe
            // the instruction that owns this access.
            alu_result_out <= alu_result_in;
            rd_addr_out    <= rd_addr_in;
            RegWrite_out   <= RegWrite_in;
            MemToReg_out   <= MemToReg_in;
            if (!dmem.dmem_we) begin
              mem_data_out <= dmem.dmem_rdata;
            end
            dmem.dmem_req <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (w_timeout) begin
            dmem.dmem_req <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemToReg_out  <= 1'b0;
            bus_err       <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt        <= r_cnt + c_cnt_w'(1);
            RegWrite_out <= 1'b0;
            MemToReg_out <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
